// File: rtl/vsub_pkg.sv
// Shared FSM state type, default geometry and signed saturation limits for the vector subtract stream.
package vsub_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_VEC_LEN = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } vsub_state_e;

  // Limits are returned 64 bits wide so any DATA_W up to 64 can truncate them.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/vsub_elem.sv
// Combinational DATA_W-bit signed subtract a_i - b_i with signed-overflow flag and optional clamp (SAT_EN).
import vsub_pkg::*;

module vsub_elem #(
  parameter int DATA_W = DEF_DATA_W,
  parameter bit SAT_EN = 1'b0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] diff_o,
  output logic              ovf_o
);

  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min(DATA_W));

  logic [DATA_W-1:0] raw;

  assign raw = a_i - b_i;

  // Overflow only when operand signs differ and the result sign disagrees with the minuend.
  assign ovf_o  = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (raw[DATA_W-1] != a_i[DATA_W-1]);
  assign diff_o = (SAT_EN && ovf_o) ? (a_i[DATA_W-1] ? SAT_MIN : SAT_MAX) : raw;

endmodule

// File: rtl/vector_sub_vector_stream.sv
// Streams out_diff = in_a - in_b per element with index/last tagging; 1-cycle latency, zero-bubble ready/valid, stalls upstream on out_ready low.
// Define VSUB_SAT_EN to clamp on signed overflow and add the sticky sat_flag output.
import vsub_pkg::*;

module vector_sub_vector_stream #(
  parameter  int VEC_LEN = DEF_VEC_LEN,
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int IDX_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_diff,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              vec_done
`ifdef VSUB_SAT_EN
  ,output logic             sat_flag
`endif
);

`ifdef VSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  vsub_state_e       state_q;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_diff_q, diff_d;
  logic [IDX_W-1:0]  out_idx_q;
  logic              out_last_q;
  logic              vec_done_q;
  logic              ovf;
  logic              in_acc, out_xfer, cnt_at_last;

  vsub_elem #(
    .DATA_W (DATA_W),
    .SAT_EN (SAT_EN)
  ) u_elem (
    .a_i    (in_a),
    .b_i    (in_b),
    .diff_o (diff_d),
    .ovf_o  (ovf)
  );

  assign in_ready    = (!out_valid_q || out_ready) && !clear;
  assign in_acc      = in_valid && in_ready;
  assign out_xfer    = out_valid_q && out_ready;
  assign cnt_at_last = (cnt_q == LAST_IDX);
  assign cnt_d       = cnt_at_last ? '0 : cnt_q + 1'b1;

`ifdef VSUB_SAT_EN
  logic sat_q;
  assign sat_flag = sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      vec_done_q  <= 1'b0;
`ifdef VSUB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else if (clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      vec_done_q  <= 1'b0;
`ifdef VSUB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      vec_done_q <= (state_q == ST_LAST) && out_xfer;

      if (in_acc) begin
        cnt_q       <= cnt_d;
        out_valid_q <= 1'b1;
        out_diff_q  <= diff_d;
        out_idx_q   <= cnt_q;
        out_last_q  <= cnt_at_last;
`ifdef VSUB_SAT_EN
        // Element 0 starts a new vector, so the sticky flag restarts there.
        sat_q       <= ((cnt_q == '0) ? 1'b0 : sat_q) | ovf;
`endif
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end

      // In LAST the output register is full, so an accept can only coincide with its transfer.
      unique case (state_q)
        ST_IDLE: if (in_acc) state_q <= cnt_at_last ? ST_LAST : ST_RUN;
        ST_RUN:  if (in_acc && cnt_at_last) state_q <= ST_LAST;
        ST_LAST: if (out_xfer) state_q <= in_acc ? (cnt_at_last ? ST_LAST : ST_RUN) : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_diff  = out_diff_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign vec_done  = vec_done_q;

endmodule

// File: tb/tb_vector_sub_vector_stream.sv
// Directed self-checking bench for vector_sub_vector_stream (VEC_LEN=100, DATA_W=32).
module tb_vector_sub_vector_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, out_valid, out_last, vec_done;
  logic [31:0] out_diff;
  logic [6:0]  out_idx;
`ifdef VSUB_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  idx;
    logic        last;
  } rec_t;

  rec_t q[$];
  int   cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -10, overlap = 0;
  logic stall_prev = 1'b0;
  rec_t stall_rec;

  always #5 clk = ~clk;

  vector_sub_vector_stream #(.VEC_LEN(100), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .vec_done  (vec_done)
`ifdef VSUB_SAT_EN
    ,.sat_flag (sat_flag)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive at a falling edge, wait for in_ready, return at the falling edge after the accept.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_rdy_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  // Output monitor, sampling mid-low-phase after the driver has settled.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_diff, out_idx, out_last}, stall_rec);
      end
      if (vec_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        q.push_back({out_diff, out_idx, out_last});
        if (out_last) begin
          last_cyc = cyc;
          if (in_valid && in_ready) overlap++;
        end
      end
      stall_prev = out_valid && !out_ready && !clear;
      stall_rec  = {out_diff, out_idx, out_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ov0;
    logic [31:0] e;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_diff", out_diff, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_vec_done", vec_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full vector a=i, b=2i
    q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) send(32'(i), 32'(2 * i));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_count", q.size(), 100);
    for (int i = 0; i < 100 && i < q.size(); i++) begin
      e = -32'(i);
      chk($sformatf("t2_el%0d", i), q[i], {e, 7'(i), (i == 99)});
    end
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_done_timing", done_cyc, last_cyc + 1);

    // Backpressure at element 5, a=3i+7, b=i
    q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      send(32'(3 * i + 7), 32'(i));
      if (i == 0) begin
        chk("lat_valid", out_valid, 1);
        chk("lat_diff", out_diff, 7);
        chk("lat_idx", out_idx, 0);
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 32'd25;
    in_b = 32'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_in_ready%0d", k), in_ready, 0);
      chk($sformatf("stall_idx%0d", k), out_idx, 5);
      chk($sformatf("stall_diff%0d", k), out_diff, 17);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 6; i < 100; i++) send(32'(3 * i + 7), 32'(i));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_count", q.size(), 100);
    for (int i = 0; i < 100 && i < q.size(); i++) begin
      e = 32'(2 * i + 7);
      chk($sformatf("t3_el%0d", i), q[i], {e, 7'(i), (i == 99)});
    end
    chk("t3_done_cnt", done_cnt - d0, 1);

    // Overflow elements, then abort with clear at element 40
    d0 = done_cnt;
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
`ifdef VSUB_SAT_EN
    chk("ovf_pos_diff", out_diff, 32'h7FFF_FFFF);
    chk("ovf_pos_sat", sat_flag, 1);
`else
    chk("ovf_pos_diff", out_diff, 32'h8000_0000);
`endif
    send(32'h8000_0000, 32'h0000_0001);
`ifdef VSUB_SAT_EN
    chk("ovf_neg_diff", out_diff, 32'h8000_0000);
`else
    chk("ovf_neg_diff", out_diff, 32'h7FFF_FFFF);
`endif
    send(32'd5, 32'd3);
    chk("post_ovf_diff", out_diff, 2);
`ifdef VSUB_SAT_EN
    chk("sat_sticky", sat_flag, 1);
`endif
    for (int i = 3; i <= 40; i++) send(32'(i), 32'd0);
    chk("pre_clear_idx", out_idx, 40);
    clear = 1'b1;
    in_a = 32'd77;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("clear_out_valid", out_valid, 0);
`ifdef VSUB_SAT_EN
    chk("clear_sat", sat_flag, 0);
`endif
    for (int i = 0; i < 100; i++) send(32'(i), 32'd5);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_count", q.size(), 100);
    for (int i = 0; i < 100 && i < q.size(); i++) begin
      e = 32'(i) - 32'd5;
      chk($sformatf("t5_el%0d", i), q[i], {e, 7'(i), (i == 99)});
    end
    chk("t5_done_cnt", done_cnt - d0, 1);

    // Asynchronous reset at element 60
    for (int i = 0; i <= 60; i++) send(32'(i), 32'd1);
    chk("pre_rst_diff", out_diff, 59);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_diff", out_diff, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_vec_done", vec_done, 0);
    chk("arst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd9, 32'd4);
    chk("post_rst_idx", out_idx, 0);
    chk("post_rst_diff", out_diff, 5);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back vectors with continuous in_valid
    q.delete();
    d0 = done_cnt;
    ov0 = overlap;
    for (int i = 0; i < 200; i++) send(32'(i), 32'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_count", q.size(), 200);
    for (int i = 0; i < 200 && i < q.size(); i++) begin
      chk($sformatf("t7_el%0d", i), q[i], {32'(i), 7'(i % 100), (i % 100 == 99)});
    end
    chk("t7_overlap", overlap - ov0, 1);
    chk("t7_done_cnt", done_cnt - d0, 2);
    chk("t7_done_timing", done_cyc, last_cyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
